// File: rtl/rsa_uart_host_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rsa_uart_host_if                                           |
// | Description : Request/response handshake between a host and the          |
// |               rsa_uart_host serial requester.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface rsa_uart_host_if #(
  parameter int unsigned WIDTH_MSG = 8
);
  logic                 req_i;
  logic [WIDTH_MSG-1:0] msg_i;
  logic                 busy_o;
  logic                 done_o;
  logic [WIDTH_MSG-1:0] resp_o;
  logic                 timeout_o;

  modport master (
    output req_i, msg_i,
    input  busy_o, done_o, resp_o, timeout_o
  );

  modport slave (
    input  req_i, msg_i,
    output busy_o, done_o, resp_o, timeout_o
  );
endinterface
`default_nettype wire

// File: rtl/rsa_uart_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rsa_uart_host                                              |
// | Description : 8N1 UART requester: sends one byte, returns the one-byte   |
// |               reply. Optional response timeout: RSA_HOST_TIMEOUT_EN.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rsa_uart_host #(
  parameter int unsigned CLK_FRQ     = 25_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned WIDTH_MSG   = 8,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  rsa_uart_host_if.slave     host,
  output logic               tx,
  input  logic               rx
);

  localparam int unsigned c_div = (CLK_FRQ + BAUD / 2) / BAUD;
  localparam int unsigned CW    = $clog2(c_div);
  localparam logic [CW-1:0] c_div_last = CW'(c_div - 1);
  localparam logic [CW-1:0] c_div_half = CW'(c_div / 2);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_TX_START = 4'd1,
    S_TX_DATA  = 4'd2,
    S_TX_STOP  = 4'd3,
    S_RX_HUNT  = 4'd4,
    S_RX_START = 4'd5,
    S_RX_DATA  = 4'd6,
    S_RX_STOP  = 4'd7
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit;
  logic [WIDTH_MSG-1:0] r_tx_shift;
  logic [WIDTH_MSG-1:0] r_rx_shift;
  logic [WIDTH_MSG-1:0] r_resp;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_tx;
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic                 r_rx_prev;

`ifdef RSA_HOST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] c_to_last = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] c_to_one  = TW'(1);

  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;
  logic          w_in_rx;
  logic          w_stop_ok;

  assign w_in_rx   = (r_state == S_RX_HUNT) || (r_state == S_RX_START) ||
                     (r_state == S_RX_DATA) || (r_state == S_RX_STOP);
  // A good stop bit in the same cycle as the timeout takes precedence.
  assign w_stop_ok = (r_state == S_RX_STOP) && (r_cnt == '0) && r_rx_sync;
  assign host.timeout_o = r_timeout;
`else
  // The limit is only meaningful when the timeout counter is built in.
  if (TIMEOUT_CYC == 0) begin : g_timeout_unused
  end
  assign host.timeout_o = 1'b0;
`endif

  assign tx          = r_tx;
  assign host.busy_o = r_busy;
  assign host.done_o = r_done;
  assign host.resp_o = r_resp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_resp     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx       <= 1'b1;
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
`ifdef RSA_HOST_TIMEOUT_EN
      r_to_cnt   <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_done    <= 1'b0;
`ifdef RSA_HOST_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (host.req_i) begin
            r_tx_shift <= host.msg_i;
            r_busy     <= 1'b1;
            r_tx       <= 1'b0;
            r_cnt      <= c_div_last;
            r_state    <= S_TX_START;
          end
        end
        S_TX_START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            r_cnt   <= c_div_last;
            r_bit   <= '0;
            r_tx    <= r_tx_shift[0];
            r_state <= S_TX_DATA;
          end
        end
        S_TX_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            r_cnt <= c_div_last;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_TX_STOP;
            end else begin
              r_bit      <= r_bit + 3'd1;
              r_tx       <= r_tx_shift[1];
              r_tx_shift <= {1'b0, r_tx_shift[WIDTH_MSG-1:1]};
            end
          end
        end
        S_TX_STOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            r_state <= S_RX_HUNT;
`ifdef RSA_HOST_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end
        S_RX_HUNT: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_cnt   <= c_div_half;
            r_state <= S_RX_START;
          end
        end
        S_RX_START: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else if (r_rx_sync) begin
            r_state <= S_RX_HUNT;
          end else begin
            r_cnt   <= c_div_last;
            r_bit   <= '0;
            r_state <= S_RX_DATA;
          end
        end
        S_RX_DATA: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            r_cnt      <= c_div_last;
            r_rx_shift <= {r_rx_sync, r_rx_shift[WIDTH_MSG-1:1]};
            if (r_bit == 3'd7) begin
              r_state <= S_RX_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        S_RX_STOP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else if (r_rx_sync) begin
            r_resp  <= r_rx_shift;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RX_HUNT;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
`ifdef RSA_HOST_TIMEOUT_EN
      if (w_in_rx && !w_stop_ok) begin
        if (r_to_cnt == c_to_last) begin
          r_timeout <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end else begin
          r_to_cnt <= r_to_cnt + c_to_one;
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rsa_uart_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rsa_uart_host                                           |
// | Description : Bench for rsa_uart_host; models the RSA core (e=7, n=33).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rsa_uart_host;

  localparam int DIV = 10;
  localparam int TO  = 500;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic tx;

  rsa_uart_host_if #(.WIDTH_MSG(8)) hif ();

  rsa_uart_host #(
    .CLK_FRQ    (1_000_000),
    .BAUD       (100_000),
    .WIDTH_MSG  (8),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .host (hif),
    .tx   (tx),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         to_cnt   = 0;
  logic [7:0] done_resp = '0;
  logic       done_busy = 1'b0;

  // Records every completion pulse so checks can run after a frame is sent.
  always @(negedge clk) begin
    if (hif.done_o === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_resp = hif.resp_o;
      done_busy = hif.busy_o;
    end
    if (hif.timeout_o === 1'b1) to_cnt = to_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rsa_model(input logic [7:0] m);
    int r = 1;
    for (int i = 0; i < 7; i++) r = (r * int'(m)) % 33;
    return 8'(r);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_req(input logic [7:0] m);
    hif.msg_i = m;
    hif.req_i = 1'b1;
    @(negedge clk);
    hif.req_i = 1'b0;
  endtask

  // Independent receiver: find the start bit, then sample each bit mid-period.
  task automatic core_receive(output logic [7:0] b, output logic stop, output bit seen);
    int waited = 0;
    b = '0; stop = 1'b0; seen = 1'b0;
    while (tx !== 1'b0 && waited < 30 * DIV) begin
      @(negedge clk);
      waited++;
    end
    if (tx === 1'b0) begin
      seen = 1'b1;
      cycles(DIV / 2);
      for (int i = 0; i < 8; i++) begin
        cycles(DIV);
        b[i] = tx;
      end
      cycles(DIV);
      stop = tx;
      cycles(DIV / 2 + 1);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(DIV);
    end
    rx = stop;
    cycles(DIV);
    rx = 1'b1;
    cycles(2 * DIV);
  endtask

  task automatic run_txn(input logic [7:0] m, input string tag);
    logic [7:0] b;
    logic       st;
    bit         seen;
    int         d0;
    d0 = done_cnt;
    start_req(m);
    core_receive(b, st, seen);
    check({tag, "_frame_seen"}, 32'(seen), 32'd1);
    check({tag, "_tx_byte"}, 32'(b), 32'(m));
    check({tag, "_tx_stop"}, 32'(st), 32'd1);
    send_frame(rsa_model(m), 1'b1);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_resp"}, 32'(done_resp), 32'(rsa_model(m)));
    check({tag, "_busy_at_done"}, 32'(done_busy), 32'd0);
  endtask

  logic [7:0] b;
  logic       st;
  bit         seen;
  int         d0;
  int         t0;
  int         bad;
  int         k;
  logic [9:0] fr;
  logic       samp [0:10*DIV-1];
  logic [7:0] m;
  logic [7:0] last_resp;

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hif.req_i = 1'b0;
    hif.msg_i = '0;

    // Reset state
    reset = 1'b0;
    cycles(3);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(hif.busy_o), 32'd0);
    check("reset_done", 32'(hif.done_o), 32'd0);
    check("reset_timeout", 32'(hif.timeout_o), 32'd0);
    check("reset_resp", 32'(hif.resp_o), 32'd0);
    reset = 1'b1;
    cycles(2);

    // Exact transmit framing for 0x02
    d0 = done_cnt;
    m  = 8'h02;
    fr = {1'b1, m, 1'b0};
    start_req(m);
    check("accept_busy", 32'(hif.busy_o), 32'd1);
    for (int i = 0; i < 10 * DIV; i++) begin
      samp[i] = tx;
      cycles(1);
    end
    check("tx_first_low", 32'(samp[0]), 32'd0);
    bad = 0;
    for (int i = 0; i < 10 * DIV; i++) if (samp[i] !== fr[i / DIV]) bad++;
    check("tx_frame_all_samples_bad", 32'(bad), 32'd0);
    for (int j = 0; j < 10; j++) check($sformatf("tx_bit%0d", j), 32'(samp[j * DIV + DIV / 2]), 32'(fr[j]));
    send_frame(rsa_model(m), 1'b1);
    check("t2_done_count", 32'(done_cnt - d0), 32'd1);
    check("t2_resp", 32'(done_resp), 32'(rsa_model(m)));
    check("t2_busy_at_done", 32'(done_busy), 32'd0);
    check("t2_resp_held", 32'(hif.resp_o), 32'(rsa_model(m)));

    // Second request while busy is ignored
    d0 = done_cnt;
    m  = 8'h03;
    start_req(m);
    fork
      core_receive(b, st, seen);
      begin
        cycles(30);
        hif.msg_i = 8'h11;
        hif.req_i = 1'b1;
        cycles(1);
        hif.req_i = 1'b0;
      end
    join
    check("t3_tx_byte", 32'(b), 32'(m));
    send_frame(rsa_model(m), 1'b1);
    bad = 0;
    for (int i = 0; i < 30 * DIV; i++) begin
      if (tx !== 1'b1 || hif.busy_o !== 1'b0) bad++;
      cycles(1);
    end
    check("t3_no_second_frame", 32'(bad), 32'd0);
    check("t3_done_count", 32'(done_cnt - d0), 32'd1);
    check("t3_resp", 32'(done_resp), 32'(rsa_model(m)));

    // Start-bit glitch then a valid 0x2A reply
    d0 = done_cnt;
    start_req(8'($urandom_range(0, 32)));
    core_receive(b, st, seen);
    rx = 1'b0;
    cycles(3);
    rx = 1'b1;
    cycles(2 * DIV);
    check("t4_busy_after_glitch", 32'(hif.busy_o), 32'd1);
    check("t4_no_done_on_glitch", 32'(done_cnt - d0), 32'd0);
    send_frame(8'h2A, 1'b1);
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);
    check("t4_resp", 32'(done_resp), 32'h2A);

    // Framing error, then a valid 0x05 reply
    d0 = done_cnt;
    start_req(8'($urandom_range(0, 32)));
    core_receive(b, st, seen);
    send_frame(8'h77, 1'b0);
    check("t5_no_done_bad_stop", 32'(done_cnt - d0), 32'd0);
    check("t5_busy_bad_stop", 32'(hif.busy_o), 32'd1);
    send_frame(8'h05, 1'b1);
    check("t5_done_count", 32'(done_cnt - d0), 32'd1);
    check("t5_resp", 32'(done_resp), 32'h05);

    // Randomised transactions against the RSA model
    for (int t = 0; t < 4; t++) run_txn(8'($urandom_range(0, 32)), $sformatf("rand%0d", t));

    // No reply at all
    last_resp = done_resp;
    d0 = done_cnt;
    t0 = to_cnt;
    start_req(8'h04);
`ifdef RSA_HOST_TIMEOUT_EN
    k = 1;
    while (hif.timeout_o !== 1'b1 && k < 4 * TO + 10 * DIV) begin
      @(negedge clk);
      k++;
    end
    check("t6_timeout_latency", 32'(k), 32'(1 + 10 * DIV + TO));
    check("t6_busy_at_timeout", 32'(hif.busy_o), 32'd0);
    check("t6_resp_unchanged", 32'(hif.resp_o), 32'(last_resp));
    cycles(2);
    check("t6_timeout_pulses", 32'(to_cnt - t0), 32'd1);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
`else
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (hif.busy_o !== 1'b1 || hif.timeout_o !== 1'b0) bad++;
      cycles(1);
    end
    check("t6_busy_held_bad", 32'(bad), 32'd0);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_resp_unchanged", 32'(hif.resp_o), 32'(last_resp));
`endif

    // Mid-frame reset aborts the frame and clears state
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(2);
    start_req(8'h00);
    cycles(20);
    check("t7_tx_low_mid_frame", 32'(tx), 32'd0);
    reset = 1'b0;
    cycles(1);
    check("t7_tx_after_reset", 32'(tx), 32'd1);
    check("t7_busy_after_reset", 32'(hif.busy_o), 32'd0);
    check("t7_resp_after_reset", 32'(hif.resp_o), 32'd0);
    reset = 1'b1;
    cycles(2);
    run_txn(8'($urandom_range(0, 32)), "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
